// File: rtl/wowi_flip_master_if.sv
// Word-wide st_read/st_write/ready bus between the flip master and the byte-serialising adapter.
interface wowi_flip_master_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                             st_read;
    logic                             st_write;
    logic [ADDR_WIDTH-1:0]            base_addr;
    logic [WORD_BYTES*DATA_WIDTH-1:0] write_data;
    logic [WORD_BYTES*DATA_WIDTH-1:0] read_data;
    logic                             ready;

    modport master (
        output st_read,
        output st_write,
        output base_addr,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  st_read,
        input  st_write,
        input  base_addr,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/wowi_flip_master.sv
// Copies num_words words from src_base to dst_base, reversing the byte order of each word,
// by alternating one word read and one word write on the adapter bus.
module wowi_flip_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_base_i,
    input  logic [ADDR_WIDTH-1:0] dst_base_i,
    input  logic [ADDR_WIDTH-1:0] num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    wowi_flip_master_if.master    bus
);
    localparam int unsigned WordWidth = WORD_BYTES * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WordStride = ADDR_WIDTH'(WORD_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StRdCap,
        StWrReq,
        StWrWait,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] num_q, num_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WordWidth-1:0]  wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  st_read_q, st_read_d;
    logic                  st_write_q, st_write_d;
    logic [WordWidth-1:0]  flipped;

    always_comb begin
        flipped = '0;
        for (int k = 0; k < int'(WORD_BYTES); k++) begin
            flipped[k*DATA_WIDTH +: DATA_WIDTH] =
                bus.read_data[(int'(WORD_BYTES) - 1 - k)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        num_d   = num_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // busy stays high through DONE and the cycle that leaves it
        busy_d  = (state_q != StIdle);
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d  = src_base_i;
                    dst_d  = dst_base_i;
                    num_d  = num_words_i;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (num_words_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRdReq;
                        addr_d  = src_base_i;
                    end
                end
            end
            StRdReq: state_d = StRdWait;
            StRdWait: begin
                if (bus.ready) state_d = StRdCap;
            end
            StRdCap: begin
                // The last byte lane lands on the ready edge, so capture one cycle later.
                wdata_d = flipped;
                addr_d  = dst_q + idx_q * WordStride;
                state_d = StWrReq;
            end
            StWrReq: state_d = StWrWait;
            StWrWait: begin
                if (bus.ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_d == num_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRdReq;
                        addr_d  = src_q + idx_d * WordStride;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        st_read_d  = (state_d == StRdReq);
        st_write_d = (state_d == StWrReq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            src_q      <= '0;
            dst_q      <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            st_read_q  <= 1'b0;
            st_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            st_read_q  <= st_read_d;
            st_write_q <= st_write_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign bus.st_read    = st_read_q;
    assign bus.st_write   = st_write_q;
    assign bus.base_addr  = addr_q;
    assign bus.write_data = wdata_q;
endmodule

// File: tb/tb_wowi_flip_master.sv
// Bench for wowi_flip_master: byte-memory adapter with random latency, word-level reference
// model of the expected request stream and memory image, and directed plus random jobs.
module tb_wowi_flip_master;
    localparam int DW = 8;
    localparam int WB = 2;
    localparam int AW = 8;
    localparam int WW = DW * WB;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] src_base_i, dst_base_i, num_words_i;
    logic          busy_o, done_o;

    wowi_flip_master_if #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .ADDR_WIDTH(AW)) bus ();

    wowi_flip_master #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .src_base_i (src_base_i),
        .dst_base_i (dst_base_i),
        .num_words_i(num_words_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] snap    [256];
    req_t       exp_q[$];
    req_t       req_log[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    int         wr_cnt = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    endtask

    // Reference: word i is read at src+i*WB and written byte-reversed at dst+i*WB, in order.
    task automatic model_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [AW-1:0] num);
        logic [WW-1:0] w;
        logic [AW-1:0] a;
        for (int i = 0; i < int'(num); i++) begin
            a = src + AW'(i * WB);
            w = '0;
            for (int k = 0; k < WB; k++) w[k*DW +: DW] = ref_mem[a + AW'(WB - 1 - k)];
            exp_q.push_back('{wr: 1'b0, addr: a, data: '0});
            a = dst + AW'(i * WB);
            exp_q.push_back('{wr: 1'b1, addr: a, data: w});
            for (int k = 0; k < WB; k++) ref_mem[a + AW'(k)] = w[k*DW +: DW];
        end
    endtask

    task automatic mem_check(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(bad == 0, name, bad, 0);
    endtask

    // Adapter: answers each request after WB..WB+3 cycles with a one-cycle ready pulse.
    initial begin
        logic          a_wr, aborted;
        logic [AW-1:0] a_addr;
        logic [WW-1:0] a_data, w;
        int            lat;
        bus.ready     = 1'b0;
        bus.read_data = '0;
        forever begin
            @(negedge clk);
            bus.ready = 1'b0;
            if (rst_n && (bus.st_read || bus.st_write)) begin
                a_wr    = bus.st_write;
                a_addr  = bus.base_addr;
                a_data  = bus.write_data;
                lat     = WB + int'($urandom_range(0, 3));
                aborted = 1'b0;
                for (int c = 0; c < lat; c++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    if (aborted) break;
                end
                if (!aborted) begin
                    chk(bus.base_addr == a_addr, "addr_hold", bus.base_addr, a_addr);
                    if (a_wr) begin
                        chk(bus.write_data == a_data, "wdata_hold", bus.write_data, a_data);
                        for (int k = 0; k < WB; k++) mem[a_addr + AW'(k)] = a_data[k*DW +: DW];
                    end else begin
                        w = '0;
                        for (int k = 0; k < WB; k++) w[k*DW +: DW] = mem[a_addr + AW'(k)];
                        bus.read_data = w;
                    end
                    bus.ready = 1'b1;
                end
            end
        end
    end

    // Compare process: protocol rules and request stream against the model, every cycle.
    initial begin
        bit   outstanding = 1'b0;
        bit   prev_req = 1'b0;
        bit   req;
        req_t obs, e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                outstanding = 1'b0;
                prev_req    = 1'b0;
                continue;
            end
            if (bus.ready) outstanding = 1'b0;
            chk(!(bus.st_read && bus.st_write), "req_exclusive",
                {bus.st_read, bus.st_write}, 0);
            req = bus.st_read || bus.st_write;
            if (req) begin
                obs = '{wr: bus.st_write, addr: bus.base_addr, data: bus.write_data};
                chk(!prev_req && !outstanding, "req_spacing", {prev_req, outstanding}, 0);
                chk(busy_o, "busy_during_req", busy_o, 1);
                req_log.push_back(obs);
                if (obs.wr) wr_cnt++;
                chk(exp_q.size() != 0, "req_expected", obs.addr, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(obs.wr == e.wr, "req_kind", obs.wr, e.wr);
                    chk(obs.addr == e.addr, "req_addr", obs.addr, e.addr);
                    if (e.wr) chk(obs.data == e.data, "wr_data", obs.data, e.data);
                end
                outstanding = 1'b1;
            end
            prev_req = req;
            if (done_o) done_cnt++;
        end
    end

    task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW-1:0] num, input bit intrude, output int cyc);
        int ic = 0;
        bit saw_done = 1'b0;
        req_log.delete();
        done_cnt = 0;
        model_job(src, dst, num);
        @(negedge clk);
        start_i     = 1'b1;
        src_base_i  = src;
        dst_base_i  = dst;
        num_words_i = num;
        cyc = 0;
        while (!saw_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (cyc == 1) chk(busy_o, "busy_after_start", busy_o, 1);
            if (intrude && req_log.size() != 0) begin
                ic++;
                if (ic == 2) begin
                    start_i     = 1'b1;
                    src_base_i  = src + 8'h55;
                    dst_base_i  = dst + 8'h33;
                    num_words_i = num + 8'd3;
                end
            end
            if (done_o) saw_done = 1'b1;
        end
        chk(saw_done, "done_timeout", cyc, 0);
        @(negedge clk);
        start_i = 1'b0;
        chk(!busy_o, "busy_fall", busy_o, 0);
        chk(!done_o, "done_one_cycle", done_o, 0);
        chk(done_cnt == 1, "done_count", done_cnt, 1);
        chk(exp_q.size() == 0, "reqs_missing", exp_q.size(), 0);
        mem_check("mem_image");
    endtask

    initial begin
        int   cyc, nb;
        int   exp_multi[8] = '{'h00, 'h80, 'h02, 'h82, 'h04, 'h84, 'h06, 'h86};
        int   exp_wrap[4]  = '{'hFE, 'hFC, 'h00, 'hFE};
        logic [AW-1:0] rs, rd, rn;
        rst_n = 1'b0;
        start_i = 1'b0;
        src_base_i = '0;
        dst_base_i = '0;
        num_words_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'hAB;
        mem[8'h11] = 8'hCD;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        repeat (3) @(negedge clk);
        chk(!busy_o && !done_o, "rst_busy_done", {busy_o, done_o}, 0);
        chk(!bus.st_read && !bus.st_write, "rst_req", {bus.st_read, bus.st_write}, 0);
        chk(bus.base_addr == '0, "rst_addr", bus.base_addr, 0);
        chk(bus.write_data == '0, "rst_wdata", bus.write_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, byte-swapped literal expectations
        run_job(8'h10, 8'h40, 8'd1, 1'b0, cyc);
        chk(req_log.size() == 2, "single_nreq", req_log.size(), 2);
        if (req_log.size() == 2) begin
            chk(!req_log[0].wr && req_log[0].addr == 8'h10, "single_rd", req_log[0].addr, 'h10);
            chk(req_log[1].wr && req_log[1].addr == 8'h40, "single_wr", req_log[1].addr, 'h40);
            chk(req_log[1].data == 16'hABCD, "single_wdata", req_log[1].data, 'hABCD);
        end
        chk(mem[8'h40] == 8'hCD, "single_mem40", mem[8'h40], 'hCD);
        chk(mem[8'h41] == 8'hAB, "single_mem41", mem[8'h41], 'hAB);

        // Multi word, strictly alternating
        run_job(8'h00, 8'h80, 8'd4, 1'b0, cyc);
        chk(req_log.size() == 8, "multi_nreq", req_log.size(), 8);
        for (int i = 0; i < 8 && i < req_log.size(); i++) begin
            chk(req_log[i].addr == AW'(exp_multi[i]), "multi_addr", req_log[i].addr, exp_multi[i]);
            chk(req_log[i].wr == 1'(i % 2), "multi_alternate", req_log[i].wr, i % 2);
        end

        // Zero length
        run_job(8'h20, 8'h30, 8'd0, 1'b0, cyc);
        chk(req_log.size() == 0, "zero_nreq", req_log.size(), 0);
        chk(cyc == 2, "zero_done_latency", cyc, 2);

        // Address wrap
        run_job(8'hFE, 8'hFC, 8'd2, 1'b0, cyc);
        chk(req_log.size() == 4, "wrap_nreq", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk(req_log[i].addr == AW'(exp_wrap[i]), "wrap_addr", req_log[i].addr, exp_wrap[i]);

        // Start while busy is ignored
        run_job(8'h30, 8'h60, 8'd3, 1'b1, cyc);
        chk(req_log.size() == 6, "intrude_nreq", req_log.size(), 6);

        // Reset during WR_WAIT of word 2 of 4
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        req_log.delete();
        wr_cnt = 0;
        model_job(8'h90, 8'hC0, 8'd4);
        @(negedge clk);
        start_i = 1'b1;
        src_base_i = 8'h90;
        dst_base_i = 8'hC0;
        num_words_i = 8'd4;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        while (wr_cnt < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk(wr_cnt >= 2, "rst_job_timeout", wr_cnt, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk(!busy_o && !done_o, "midrst_busy_done", {busy_o, done_o}, 0);
        chk(!bus.st_read && !bus.st_write, "midrst_req", {bus.st_read, bus.st_write}, 0);
        chk(bus.base_addr == '0, "midrst_addr", bus.base_addr, 0);
        chk(bus.write_data == '0, "midrst_wdata", bus.write_data, 0);
        exp_q.delete();
        nb = req_log.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk(req_log.size() == nb, "no_req_after_reset", req_log.size(), nb);
        chk(!busy_o, "idle_after_reset", busy_o, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = snap[i];
        model_job(8'h90, 8'hC0, 8'd1);
        exp_q.delete();
        mem_check("mem_after_reset");
        run_job(8'h90, 8'hC0, 8'd4, 1'b0, cyc);
        chk(req_log.size() == 8, "post_reset_nreq", req_log.size(), 8);

        // Random jobs, overlaps allowed
        for (int j = 0; j < 12; j++) begin
            rs = 8'($urandom);
            rd = 8'($urandom);
            rn = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            run_job(rs, rd, rn, 1'($urandom_range(0, 1)), cyc);
            chk(req_log.size() == 2 * int'(rn), "rand_nreq", req_log.size(), 2 * int'(rn));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
